// File: rtl/alu_arbiter.sv
// alu_arbiter: grants one shared 32-bit ALU datapath to one of two requesters
// at a time. It issues the decoded select/subtract and operands, holds them for
// SETTLE_CYCLES so the gate-delayed datapath can resolve, then captures the
// result and flags into a registered valid/ready response channel.
//
// Build option: define ALU_ARB_RR_EN for a round-robin tie-break driven by a
// last_grant register. Without it, requester 0 always wins ties and
// requester 1 can starve.

module alu_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  // Request side
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [2:0]  req_cmd0,
  input  logic [2:0]  req_cmd1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  // ALU datapath
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  output logic        alu_sub,
  input  logic [31:0] alu_result,
  input  logic        alu_carryout,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  // Response side
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data,
  output logic [2:0]  resp_flags
);

  // Counter is 8 bits wide because SETTLE_CYCLES tops out at 255.
  localparam logic [7:0] CntLoad = 8'(SETTLE_CYCLES - 1);

  // Command encodings
  localparam logic [2:0] CmdAdd  = 3'd0;
  localparam logic [2:0] CmdSub  = 3'd1;
  localparam logic [2:0] CmdXor  = 3'd2;
  localparam logic [2:0] CmdSlt  = 3'd3;
  localparam logic [2:0] CmdAnd  = 3'd4;
  localparam logic [2:0] CmdNand = 3'd5;
  localparam logic [2:0] CmdNor  = 3'd6;
  localparam logic [2:0] CmdOr   = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_sel_q, alu_sel_d;
  logic        alu_sub_q, alu_sub_d;
  logic        id_q, id_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [2:0]  resp_flags_q, resp_flags_d;
`ifdef ALU_ARB_RR_EN
  logic        last_grant_q, last_grant_d;
`endif

  logic        grant;
  logic        accept;
  logic [2:0]  sel_cmd;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [2:0]  dec_sel;
  logic        dec_sub;

  // Map a command to the ALU mux select and subtract control; select 7
  // (constant zero) is never produced.
  function automatic logic [3:0] decode_cmd(input logic [2:0] cmd);
    logic [3:0] sel_sub;
    unique case (cmd)
      CmdAdd:  sel_sub = {3'd0, 1'b0};
      CmdSub:  sel_sub = {3'd0, 1'b1};
      CmdXor:  sel_sub = {3'd1, 1'b0};
      CmdSlt:  sel_sub = {3'd2, 1'b1};
      CmdAnd:  sel_sub = {3'd3, 1'b0};
      CmdNand: sel_sub = {3'd4, 1'b0};
      CmdNor:  sel_sub = {3'd5, 1'b0};
      CmdOr:   sel_sub = {3'd6, 1'b0};
      default: sel_sub = {3'd0, 1'b0};
    endcase
    return sel_sub;
  endfunction

  // Pick a requester among those currently valid.
  always_comb begin
`ifdef ALU_ARB_RR_EN
    // On a tie, favour whoever was not served last.
    grant = (&req_valid) ? ~last_grant_q : req_valid[1];
`else
    // Requester 0 wins whenever it is valid.
    grant = ~req_valid[0];
`endif
  end

  // Ready only toward the granted requester while idle; forced low in reset.
  always_comb begin
    req_ready = 2'b00;
    if (!reset && (state_q == StIdle) && (|req_valid)) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end
  end

  assign accept = |(req_valid & req_ready);

  // Route the granted requester's command and operands toward the ALU regs.
  always_comb begin
    sel_cmd = grant ? req_cmd1 : req_cmd0;
    sel_a   = grant ? req_a1   : req_a0;
    sel_b   = grant ? req_b1   : req_b0;
    {dec_sel, dec_sub} = decode_cmd(sel_cmd);
  end

  // Next-state logic for the controller and all registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    alu_sub_d    = alu_sub_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_flags_d = resp_flags_q;
`ifdef ALU_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          alu_a_d   = sel_a;
          alu_b_d   = sel_b;
          alu_sel_d = dec_sel;
          alu_sub_d = dec_sub;
          id_d      = grant;
          cnt_d     = CntLoad;
          state_d   = StWait;
`ifdef ALU_ARB_RR_EN
          last_grant_d = grant;
`endif
        end
      end
      StWait: begin
        if (cnt_q == 8'd0) begin
          resp_data_d  = alu_result;
          resp_flags_d = {alu_overflow, alu_zero, alu_carryout};
          resp_id_d    = id_q;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StResp: begin
        // ALU operands keep their last values after the response leaves.
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset; any in-flight command
  // is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      alu_sel_q    <= 3'd0;
      alu_sub_q    <= 1'b0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_flags_q <= 3'd0;
`ifdef ALU_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      alu_sub_q    <= alu_sub_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_flags_q <= resp_flags_d;
`ifdef ALU_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign alu_sub    = alu_sub_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_flags = resp_flags_q;

  // Protocol sanity checks.
  a_ready_onehot0: assert property (@(posedge clk) $onehot0(req_ready));
  a_no_zero_sel: assert property (@(posedge clk) alu_sel_q != 3'd7);
  a_resp_hold: assert property (@(posedge clk) disable iff (reset)
    (resp_valid_q && !resp_ready) |=> (resp_valid_q && $stable(resp_data_q)
                                       && $stable(resp_id_q) && $stable(resp_flags_q)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at the default settle interval
// and one with SETTLE_CYCLES = 1, each driving a behavioural ALU model.

module tb_alu_arbiter;

  logic clk;
  logic reset;

  // Default instance signals
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  req_cmd0, req_cmd1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_sel;
  logic        alu_sub, alu_carryout, alu_zero, alu_overflow;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_data;
  logic [2:0]  resp_flags;

  // SETTLE_CYCLES = 1 instance signals
  logic [1:0]  s1_req_valid;
  logic [1:0]  s1_req_ready;
  logic [2:0]  s1_req_cmd0, s1_req_cmd1;
  logic [31:0] s1_req_a0, s1_req_b0, s1_req_a1, s1_req_b1;
  logic [31:0] s1_alu_a, s1_alu_b, s1_alu_result;
  logic [2:0]  s1_alu_sel;
  logic        s1_alu_sub, s1_alu_carryout, s1_alu_zero, s1_alu_overflow;
  logic        s1_resp_valid, s1_resp_ready, s1_resp_id;
  logic [31:0] s1_resp_data;
  logic [2:0]  s1_resp_flags;

  int checks = 0;
  int errors = 0;

  localparam int Settle = 8;

  // Behavioural ALU: returns {overflow, zero, carryout, result}.
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] sel, input logic sub);
    logic [31:0] bb;
    logic [32:0] sum;
    logic [31:0] r;
    logic        ovf;
    bb  = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
    ovf = (a[31] == bb[31]) && (sum[31] != a[31]);
    case (sel)
      3'd0:    r = sum[31:0];
      3'd1:    r = a ^ b;
      3'd2:    r = {31'd0, ovf ^ sum[31]};
      3'd3:    r = a & b;
      3'd4:    r = ~(a & b);
      3'd5:    r = ~(a | b);
      3'd6:    r = a | b;
      default: r = 32'd0;
    endcase
    return {ovf, (r == 32'd0), sum[32], r};
  endfunction

  assign {alu_overflow, alu_zero, alu_carryout, alu_result} =
    alu_model(alu_a, alu_b, alu_sel, alu_sub);
  assign {s1_alu_overflow, s1_alu_zero, s1_alu_carryout, s1_alu_result} =
    alu_model(s1_alu_a, s1_alu_b, s1_alu_sel, s1_alu_sub);

  alu_arbiter #(.SETTLE_CYCLES(Settle)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_sub(alu_sub),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_flags(resp_flags)
  );

  alu_arbiter #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .reset(reset),
    .req_valid(s1_req_valid), .req_ready(s1_req_ready),
    .req_cmd0(s1_req_cmd0), .req_cmd1(s1_req_cmd1),
    .req_a0(s1_req_a0), .req_b0(s1_req_b0), .req_a1(s1_req_a1), .req_b1(s1_req_b1),
    .alu_a(s1_alu_a), .alu_b(s1_alu_b), .alu_sel(s1_alu_sel), .alu_sub(s1_alu_sub),
    .alu_result(s1_alu_result), .alu_carryout(s1_alu_carryout),
    .alu_zero(s1_alu_zero), .alu_overflow(s1_alu_overflow),
    .resp_valid(s1_resp_valid), .resp_ready(s1_resp_ready), .resp_id(s1_resp_id),
    .resp_data(s1_resp_data), .resp_flags(s1_resp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; drive and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    req_valid     = 2'b00;
    resp_ready    = 1'b0;
    s1_req_valid  = 2'b00;
    s1_resp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b11;
    s1_req_valid = 2'b11;
    tick();
    checks++;
    if ({req_ready, alu_a, alu_b, alu_sel, alu_sub, resp_valid, resp_id, resp_data,
         resp_flags} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b a=%h b=%h sel=%0d sub=%b rv=%b id=%b d=%h f=%b want all 0",
               req_ready, alu_a, alu_b, alu_sel, alu_sub, resp_valid, resp_id, resp_data,
               resp_flags);
    end
    checks++;
    if ({s1_req_ready, s1_resp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs_s1: got ready=%b rv=%b want 00 0", s1_req_ready, s1_resp_valid);
    end
    reset = 1'b0;
    #1;
    // First tie after reset goes to requester 0 in either build.
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_tie: got req_ready=%b want 01", req_ready);
    end
    req_valid = 2'b00;
    s1_req_valid = 2'b00;
  endtask

  task automatic test_sub();
    int n;
    do_reset();
    req_cmd0 = 3'd1; req_a0 = 32'd5; req_b0 = 32'd7;
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL sub_ready: got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    checks++;
    if ({alu_a, alu_b, alu_sel, alu_sub, req_ready, resp_valid} !==
        {32'd5, 32'd7, 3'd0, 1'b1, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL sub_issue: got a=%h b=%h sel=%0d sub=%b ready=%b rv=%b want 5 7 0 1 00 0",
               alu_a, alu_b, alu_sel, alu_sub, req_ready, resp_valid);
    end
    n = 0;
    while (!resp_valid && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != Settle) begin
      errors++;
      $display("FAIL sub_latency: got %0d cycles want %0d", n, Settle);
    end
    checks++;
    if ({resp_valid, resp_id, resp_data, resp_flags} !== {1'b1, 1'b0, 32'hFFFF_FFFE, 3'b000})
    begin
      errors++;
      $display("FAIL sub_resp: got v=%b id=%b d=%h f=%b want 1 0 fffffffe 000",
               resp_valid, resp_id, resp_data, resp_flags);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sub_resp_drop: got resp_valid=%b want 0", resp_valid);
    end
  endtask

  task automatic test_slt_backpressure();
    int n;
    do_reset();
    req_cmd1 = 3'd3; req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1;
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL slt_ready: got %b want 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    n = 0;
    // Operands and select must stay put for the whole settle window.
    while (!resp_valid && n < 40) begin
      checks++;
      if ({alu_a, alu_b, alu_sel, alu_sub} !== {32'hFFFF_FFFF, 32'd1, 3'd2, 1'b1}) begin
        errors++;
        $display("FAIL slt_hold: got a=%h b=%h sel=%0d sub=%b want ffffffff 1 2 1",
                 alu_a, alu_b, alu_sel, alu_sub);
      end
      tick();
      n++;
    end
    checks++;
    if (n != Settle) begin
      errors++;
      $display("FAIL slt_latency: got %0d want %0d", n, Settle);
    end
    // Both requesters push while the response is stalled.
    req_cmd0 = 3'd0; req_a0 = 32'd9; req_b0 = 32'd9;
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({resp_valid, resp_id, resp_data, resp_flags, req_ready} !==
          {1'b1, 1'b1, 32'd1, 3'b001, 2'b00}) begin
        errors++;
        $display("FAIL slt_stall[%0d]: got v=%b id=%b d=%h f=%b ready=%b want 1 1 00000001 001 00",
                 i, resp_valid, resp_id, resp_data, resp_flags, req_ready);
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if ({resp_valid, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL slt_release: got rv=%b ready=%b want 0 01", resp_valid, req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    do_reset();
    req_cmd0 = 3'd2; req_a0 = 32'h1234_5678; req_b0 = 32'hFFFF_0000;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    tick();
    reset = 1'b1;
    req_valid = 2'b01;
    tick();
    checks++;
    if ({req_ready, alu_a, alu_b, alu_sel, alu_sub, resp_valid, resp_id, resp_data,
         resp_flags} !== '0) begin
      errors++;
      $display("FAIL midwait_reset: got ready=%b a=%h b=%h sel=%0d sub=%b rv=%b want all 0",
               req_ready, alu_a, alu_b, alu_sel, alu_sub, resp_valid);
    end
    reset = 1'b0;
    req_valid = 2'b00;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midwait_no_resp: got %0d valid cycles want 0", seen);
    end
    // A fresh AND afterwards completes with a zero result.
    req_cmd0 = 3'd4; req_a0 = 32'h0000_00F0; req_b0 = 32'h0000_000F;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 40 && !resp_valid; i++) tick();
    checks++;
    if ({resp_valid, resp_id, resp_data, resp_flags} !== {1'b1, 1'b0, 32'd0, 3'b010}) begin
      errors++;
      $display("FAIL midwait_and: got v=%b id=%b d=%h f=%b want 1 0 00000000 010",
               resp_valid, resp_id, resp_data, resp_flags);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    logic exp_id;
    do_reset();
    req_cmd0 = 3'd0; req_a0 = 32'd1;    req_b0 = 32'd2;
    req_cmd1 = 3'd7; req_a1 = 32'h10;   req_b1 = 32'h01;
    req_valid = 2'b11;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!resp_valid && n < 60) begin
        tick();
        n++;
      end
`ifdef ALU_ARB_RR_EN
      exp_id = k[0];
`else
      exp_id = 1'b0;
`endif
      // After the handshake tick, accept + settle: SETTLE_CYCLES+1 more edges.
      if (k > 0) begin
        checks++;
        if (n != Settle + 1) begin
          errors++;
          $display("FAIL b2b_spacing[%0d]: got %0d want %0d", k, n, Settle + 1);
        end
      end
      checks++;
      if ({resp_valid, resp_id, resp_data} !==
          {1'b1, exp_id, (exp_id ? 32'h11 : 32'd3)}) begin
        errors++;
        $display("FAIL b2b_resp[%0d]: got v=%b id=%b d=%h want id=%b", k, resp_valid,
                 resp_id, resp_data, exp_id);
      end
      tick();
    end
    req_valid = 2'b00;
    resp_ready = 1'b0;
    tick();
  endtask

  task automatic test_settle_one();
    do_reset();
    s1_req_cmd0 = 3'd5; s1_req_a0 = 32'hF0F0_F0F0; s1_req_b0 = 32'hFFFF_0000;
    s1_req_cmd1 = 3'd0; s1_req_a1 = 32'd0; s1_req_b1 = 32'd0;
    s1_req_valid = 2'b01;
    tick();
    s1_req_valid = 2'b00;
    checks++;
    if ({s1_resp_valid, s1_alu_sel, s1_alu_sub} !== {1'b0, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL s1_issue: got rv=%b sel=%0d sub=%b want 0 4 0", s1_resp_valid,
               s1_alu_sel, s1_alu_sub);
    end
    tick();
    checks++;
    if ({s1_resp_valid, s1_resp_id, s1_resp_data, s1_resp_flags} !==
        {1'b1, 1'b0, 32'h0F0F_FFFF, 3'b001}) begin
      errors++;
      $display("FAIL s1_resp: got v=%b id=%b d=%h f=%b want 1 0 0f0fffff 001",
               s1_resp_valid, s1_resp_id, s1_resp_data, s1_resp_flags);
    end
    s1_resp_ready = 1'b1;
    tick();
    s1_resp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 2'b00; resp_ready = 1'b0;
    req_cmd0 = 3'd0; req_cmd1 = 3'd0;
    req_a0 = 32'd0; req_b0 = 32'd0; req_a1 = 32'd0; req_b1 = 32'd0;
    s1_req_valid = 2'b00; s1_resp_ready = 1'b0;
    s1_req_cmd0 = 3'd0; s1_req_cmd1 = 3'd0;
    s1_req_a0 = 32'd0; s1_req_b0 = 32'd0; s1_req_a1 = 32'd0; s1_req_b1 = 32'd0;
    test_reset();
    test_sub();
    test_slt_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    test_settle_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
